mem_refill_ctrl: RTL and testbench

Memory-side agent sitting directly downstream of cacheController. It consumes req_cc2mem/adr_cc2mem and produces the ack_mem2cc/dat_mem2cc beat stream the controller expects. On a read it fetches a full cache line word by word from a single-outstanding backing-memory port, critical word first with wrap-around, and assembles the line for the MSHR path. It also performs single-word writes.

---
 rtl/mem_refill_ctrl_pkg.sv | 23 ++
 rtl/mem_refill_ctrl_refill_line_buffer.sv | 36 +++
 rtl/mem_refill_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_refill_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_refill_ctrl_pkg.sv
// Shared definitions for the cache-line refill agent: FSM states, line geometry
// and the helper that locates a word slot inside the assembled line.
package mem_refill_ctrl_pkg;

  localparam int BYTE_OFS_W       = 2;
  localparam int LINE_WORD_OFFSET = 2;
  localparam int WORDS_PER_LINE   = 1 << LINE_WORD_OFFSET;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RD_RESP  = 3'd3,
    WR_ISSUE = 3'd4,
    WR_WAIT  = 3'd5,
    WR_RESP  = 3'd6
  } state_t;

  function automatic int slot_lsb(input int word, input int width);
    return word * width;
  endfunction

endpackage

// File: rtl/mem_refill_ctrl_refill_line_buffer.sv
// Line assembly buffer: one DATA_WIDTH slot per word, each loaded by its own
// write enable, presented packed with word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
module mem_refill_ctrl_refill_line_buffer
  import mem_refill_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = WORDS_PER_LINE,
  parameter int LINE_WIDTH = DATA_WIDTH * WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORDS-1:0]      we,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [LINE_WIDTH-1:0] line
);

  logic [DATA_WIDTH-1:0] slot_q [WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (we[i]) slot_q[i] <= wdat;
      end
    end
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < WORDS; i++) begin
      line[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = slot_q[i];
    end
  end

endmodule

// File: rtl/mem_refill_ctrl.sv
// Memory-side agent for the cache controller: critical-word-first line refill
// over a single-outstanding backing-memory port, plus single-word writes.
module mem_refill_ctrl
  import mem_refill_ctrl_pkg::*;
#(
  parameter int ADR_WIDTH     = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WORD_OFFSET   = 2,
  parameter int DATAMEM_WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_cc2mem,
  input  logic [ADR_WIDTH-1:0]     adr_cc2mem,
  input  logic                     rdwr_cc2mem,
  input  logic [DATA_WIDTH-1:0]    dat_cc2mem,
  output logic                     ack_mem2cc,
  output logic [DATA_WIDTH-1:0]    dat_mem2cc,
  output logic [WORD_OFFSET-1:0]   word_mem2cc,
  output logic                     done_mem2cc,
  output logic [DATAMEM_WIDTH-1:0] line_mem2cc,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADR_WIDTH-1:0]     mem_adr,
  output logic [DATA_WIDTH-1:0]    mem_wdat,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdat,
  output state_t                   state_dbg
);

  localparam int WPL  = 1 << WORD_OFFSET;
  localparam int LA_W = ADR_WIDTH - BYTE_OFS_W;

  // Backing-memory handshake: an access is accepted on a cycle where
  // mem_req && mem_gnt; mem_req/mem_adr/mem_we/mem_wdat hold steady until then.
  // Exactly one mem_rvalid pulse answers each accepted access (read data or
  // write completion); it is only honoured in RD_WAIT / WR_WAIT.

  state_t                 state, state_d;
  logic [LA_W-1:0]        adr_q, adr_d;
  logic [DATA_WIDTH-1:0]  wdat_q, wdat_d;
  logic [WORD_OFFSET-1:0] word_q, word_d, beat_q, beat_d;
  logic                   hold_q, hold_d;
  logic [WPL-1:0]         buf_we;

  logic                   ack_d, done_d, mem_req_d, mem_we_d;
  logic [DATA_WIDTH-1:0]  dat_d, mem_wdat_d;
  logic [WORD_OFFSET-1:0] word_out_d;
  logic [ADR_WIDTH-1:0]   mem_adr_d;

  logic unused_adr_lsb;
  assign unused_adr_lsb = ^adr_cc2mem[BYTE_OFS_W-1:0];

  assign state_dbg = state;

  always_comb begin
    state_d = state;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    word_d  = word_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    buf_we  = '0;
    dat_d   = '0;

    unique case (state)
      IDLE: begin
        if (req_cc2mem && !hold_q) begin
          adr_d  = adr_cc2mem[ADR_WIDTH-1:BYTE_OFS_W];
          wdat_d = dat_cc2mem;
          if (rdwr_cc2mem) begin
            state_d = WR_ISSUE;
          end else begin
            state_d = RD_ISSUE;
            word_d  = adr_cc2mem[WORD_OFFSET+BYTE_OFS_W-1:BYTE_OFS_W];
            beat_d  = '0;
          end
        end
      end
      RD_ISSUE: if (mem_gnt) state_d = RD_WAIT;
      RD_WAIT: begin
        if (mem_rvalid) begin
          buf_we[word_q] = 1'b1;
          dat_d          = mem_rdat;
          state_d        = RD_RESP;
        end
      end
      RD_RESP: begin
        if (beat_q == '1) begin
          hold_d  = 1'b1;
          state_d = IDLE;
        end else begin
          word_d  = word_q + 1'b1;
          beat_d  = beat_q + 1'b1;
          state_d = RD_ISSUE;
        end
      end
      WR_ISSUE: if (mem_gnt) state_d = WR_WAIT;
      WR_WAIT:  if (mem_rvalid) state_d = WR_RESP;
      WR_RESP: begin
        hold_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Dropping req re-arms acceptance; it wins over a same-cycle completion.
    if (!req_cc2mem) hold_d = 1'b0;

    mem_req_d  = (state_d == RD_ISSUE) || (state_d == WR_ISSUE);
    mem_we_d   = (state_d == WR_ISSUE);
    mem_wdat_d = (state_d == WR_ISSUE) ? wdat_d : '0;
    mem_adr_d  = '0;
    if (state_d == RD_ISSUE) begin
      mem_adr_d = {adr_d[LA_W-1:WORD_OFFSET], word_d, {BYTE_OFS_W{1'b0}}};
    end else if (state_d == WR_ISSUE) begin
      mem_adr_d = {adr_d, {BYTE_OFS_W{1'b0}}};
    end
    ack_d      = (state_d == RD_RESP) || (state_d == WR_RESP);
    done_d     = (state_d == WR_RESP) || ((state_d == RD_RESP) && (beat_q == '1));
    word_out_d = '0;
    if (state_d == RD_RESP)      word_out_d = word_q;
    else if (state_d == WR_RESP) word_out_d = adr_q[WORD_OFFSET-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      adr_q       <= '0;
      wdat_q      <= '0;
      word_q      <= '0;
      beat_q      <= '0;
      hold_q      <= 1'b0;
      ack_mem2cc  <= 1'b0;
      done_mem2cc <= 1'b0;
      dat_mem2cc  <= '0;
      word_mem2cc <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_adr     <= '0;
      mem_wdat    <= '0;
    end else begin
      state       <= state_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      word_q      <= word_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      ack_mem2cc  <= ack_d;
      done_mem2cc <= done_d;
      dat_mem2cc  <= dat_d;
      word_mem2cc <= word_out_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_adr     <= mem_adr_d;
      mem_wdat    <= mem_wdat_d;
    end
  end

  mem_refill_ctrl_refill_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (WPL),
    .LINE_WIDTH (DATAMEM_WIDTH)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst),
    .we    (buf_we),
    .wdat  (dat_d),
    .line  (line_mem2cc)
  );

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// Directed bench for mem_refill_ctrl: wrapped refills, writes, grant stalls,
// request hold-off, mid-transaction reset and early request drop.
module tb_mem_refill_ctrl;
  import mem_refill_ctrl_pkg::*;

  logic         clk, rst;
  logic         req_cc2mem, rdwr_cc2mem;
  logic [31:0]  adr_cc2mem, dat_cc2mem;
  logic         ack_mem2cc, done_mem2cc;
  logic [31:0]  dat_mem2cc;
  logic [1:0]   word_mem2cc;
  logic [127:0] line_mem2cc;
  logic         mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0]  mem_adr, mem_wdat, mem_rdat;
  state_t       state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  bit          gnt_level = 1'b1;
  bit          auto_rv   = 1'b1;
  bit          rv_due    = 1'b0;
  logic [31:0] rv_data;

  logic [127:0] exp_line = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};

  int           n_acks, n_issue, done_cyc;
  logic [1:0]   ack_word [4];
  logic [31:0]  ack_dat [4];
  logic         ack_done [4];
  int           ack_cyc [4];
  logic [31:0]  issue_adr [4];
  logic [127:0] done_line;

  mem_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .req_cc2mem(req_cc2mem), .adr_cc2mem(adr_cc2mem),
    .rdwr_cc2mem(rdwr_cc2mem), .dat_cc2mem(dat_cc2mem),
    .ack_mem2cc(ack_mem2cc), .dat_mem2cc(dat_mem2cc),
    .word_mem2cc(word_mem2cc), .done_mem2cc(done_mem2cc),
    .line_mem2cc(line_mem2cc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdat(mem_rdat),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // backing memory: word i of any line reads as A000000i, response one cycle after grant
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdat = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_gnt = gnt_level;
      if (auto_rv) begin
        mem_rvalid = rv_due;
        mem_rdat   = rv_due ? rv_data : 32'h0;
        rv_due     = 1'b0;
        if (mem_req && mem_gnt) begin
          rv_due  = 1'b1;
          rv_data = 32'hA0000000 | {30'b0, mem_adr[3:2]};
        end
      end else begin
        rv_due = 1'b0;
      end
    end
  end

  // driver: run one refill from the current negedge and record what comes back
  task automatic collect_read(input logic [31:0] adr, input bit drop_after_first);
    bit prev_req, finished;
    n_acks = 0; n_issue = 0; done_cyc = -1; done_line = '0;
    prev_req = 1'b0; finished = 1'b0;
    req_cc2mem = 1'b1; rdwr_cc2mem = 1'b0; adr_cc2mem = adr; dat_cc2mem = $urandom;
    for (int cyc = 1; cyc <= 80 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        adr_cc2mem = ~adr; rdwr_cc2mem = 1'b1; dat_cc2mem = $urandom;
      end
      if (mem_req && !prev_req && n_issue < 4) begin
        issue_adr[n_issue] = mem_adr;
        n_issue++;
      end
      prev_req = mem_req;
      if (ack_mem2cc) begin
        if (n_acks < 4) begin
          ack_word[n_acks] = word_mem2cc;
          ack_dat[n_acks]  = dat_mem2cc;
          ack_done[n_acks] = done_mem2cc;
          ack_cyc[n_acks]  = cyc;
        end
        n_acks++;
        if (done_mem2cc) begin
          done_cyc = cyc; done_line = line_mem2cc; finished = 1'b1;
        end
        if (n_acks == 1 && drop_after_first) req_cc2mem = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_cc2mem = 1'b0; rdwr_cc2mem = 1'b0; adr_cc2mem = '0; dat_cc2mem = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ack_mem2cc, done_mem2cc, dat_mem2cc, word_mem2cc, line_mem2cc,
         mem_req, mem_we, mem_adr, mem_wdat} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ack=%0b done=%0b dat=%h line=%h req=%0b adr=%h, required all 0",
               ack_mem2cc, done_mem2cc, dat_mem2cc, line_mem2cc, mem_req, mem_adr);
    end
    n_cmp++;
    if (state_dbg !== IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d required %0d", state_dbg, IDLE);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0 || ack_mem2cc !== 1'b0) begin
      n_err++; $display("FAIL idle_quiet: mem_req=%0b ack=%0b required 0/0", mem_req, ack_mem2cc);
    end
  endtask

  task automatic test_read_wrap();
    int ord [4] = '{2, 3, 0, 1};
    collect_read(32'hFF07BD08, 1'b0);
    n_cmp++;
    if (n_acks !== 4) begin
      n_err++; $display("FAIL wrap_ack_count: got %0d required 4", n_acks);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ack_word[i] !== 2'(ord[i]) || ack_dat[i] !== (32'hA0000000 + 32'(ord[i])) ||
          ack_done[i] !== (i == 3) || ack_cyc[i] !== 3 * (i + 1)) begin
        n_err++;
        $display("FAIL wrap_beat%0d: word=%0d dat=%h done=%0b cyc=%0d required word=%0d dat=%h done=%0b cyc=%0d",
                 i, ack_word[i], ack_dat[i], ack_done[i], ack_cyc[i],
                 ord[i], 32'hA0000000 + 32'(ord[i]), (i == 3), 3 * (i + 1));
      end
      n_cmp++;
      if (issue_adr[i] !== (32'hFF07BD00 | 32'(ord[i] << 2))) begin
        n_err++; $display("FAIL wrap_mem_adr%0d: got %h required %h", i, issue_adr[i],
                          32'hFF07BD00 | 32'(ord[i] << 2));
      end
    end
    n_cmp++;
    if (done_line !== exp_line) begin
      n_err++; $display("FAIL wrap_line: got %h required %h", done_line, exp_line);
    end
    req_cc2mem = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] w_adr  [2] = '{32'hFFFFFD08, 32'h00000013};
    logic [31:0] w_dat  [2] = '{32'h55454552, 32'h0BADF00D};
    logic [31:0] w_madr [2] = '{32'hFFFFFD08, 32'h00000010};
    logic [1:0]  w_word [2] = '{2'd2, 2'd0};
    for (int t = 0; t < 2; t++) begin
      int acks, a_cyc;
      bit a_done, seen_iss, i_we;
      logic [31:0] a_dat, i_adr, i_wdat;
      logic [1:0] a_word;
      acks = 0; a_cyc = -1; seen_iss = 1'b0;
      a_done = 1'b0; a_dat = 'x; a_word = 'x; i_we = 1'b0; i_adr = 'x; i_wdat = 'x;
      req_cc2mem = 1'b1; rdwr_cc2mem = 1'b1; adr_cc2mem = w_adr[t]; dat_cc2mem = w_dat[t];
      for (int cyc = 1; cyc <= 12; cyc++) begin
        @(negedge clk);
        if (cyc == 1) begin adr_cc2mem = 32'h0; dat_cc2mem = 32'hFFFFFFFF; rdwr_cc2mem = 1'b0; end
        if (mem_req && !seen_iss) begin
          seen_iss = 1'b1; i_we = mem_we; i_adr = mem_adr; i_wdat = mem_wdat;
        end
        if (ack_mem2cc) begin
          acks++; a_cyc = cyc; a_done = done_mem2cc; a_dat = dat_mem2cc; a_word = word_mem2cc;
        end
      end
      n_cmp++;
      if (i_we !== 1'b1 || i_adr !== w_madr[t] || i_wdat !== w_dat[t]) begin
        n_err++; $display("FAIL write%0d_issue: we=%0b adr=%h wdat=%h required 1 %h %h",
                          t, i_we, i_adr, i_wdat, w_madr[t], w_dat[t]);
      end
      n_cmp++;
      if (acks !== 1 || a_cyc !== 3 || a_done !== 1'b1 || a_dat !== 32'h0 || a_word !== w_word[t]) begin
        n_err++; $display("FAIL write%0d_ack: acks=%0d cyc=%0d done=%0b dat=%h word=%0d required 1 3 1 0 %0d",
                          t, acks, a_cyc, a_done, a_dat, a_word, w_word[t]);
      end
      req_cc2mem = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_gnt_stall();
    int acks, stall_cnt;
    bit fin;
    logic [1:0] words [4];
    int cycs [4];
    acks = 0; stall_cnt = -1; fin = 1'b0;
    req_cc2mem = 1'b1; rdwr_cc2mem = 1'b0; adr_cc2mem = 32'h00001000;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 1) adr_cc2mem = 32'h00002FFC;
      if (stall_cnt >= 0 && stall_cnt < 5) begin
        n_cmp++;
        if (mem_req !== 1'b1 || mem_adr !== 32'h00001004 || ack_mem2cc !== 1'b0) begin
          n_err++; $display("FAIL stall_cyc%0d: req=%0b adr=%h ack=%0b required 1 00001004 0",
                            stall_cnt, mem_req, mem_adr, ack_mem2cc);
        end
        stall_cnt++;
        if (stall_cnt == 5) gnt_level = 1'b1;
      end
      if (ack_mem2cc) begin
        if (acks < 4) begin words[acks] = word_mem2cc; cycs[acks] = cyc; end
        acks++;
        if (acks == 1) begin gnt_level = 1'b0; stall_cnt = 0; end
        if (done_mem2cc) begin fin = 1'b1; done_line = line_mem2cc; end
      end
    end
    gnt_level = 1'b1;
    n_cmp++;
    if (acks !== 4 || words[0] !== 2'd0 || words[1] !== 2'd1 || words[2] !== 2'd2 || words[3] !== 2'd3) begin
      n_err++; $display("FAIL stall_order: acks=%0d words=%0d,%0d,%0d,%0d required 4 0,1,2,3",
                        acks, words[0], words[1], words[2], words[3]);
    end
    n_cmp++;
    if (cycs[0] !== 3 || cycs[1] !== 10 || cycs[2] !== 13 || cycs[3] !== 16) begin
      n_err++; $display("FAIL stall_timing: cycs=%0d,%0d,%0d,%0d required 3,10,13,16",
                        cycs[0], cycs[1], cycs[2], cycs[3]);
    end
    n_cmp++;
    if (done_line !== exp_line) begin
      n_err++; $display("FAIL stall_line: got %h required %h", done_line, exp_line);
    end
    req_cc2mem = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_after_done();
    collect_read(32'h00000040, 1'b0);
    n_cmp++;
    if (n_acks !== 4 || done_cyc !== 12) begin
      n_err++; $display("FAIL hold_first_line: acks=%0d done_cyc=%0d required 4 12", n_acks, done_cyc);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_req !== 1'b0 || ack_mem2cc !== 1'b0) begin
        n_err++; $display("FAIL hold_reserve%0d: mem_req=%0b ack=%0b required 0 0", i, mem_req, ack_mem2cc);
      end
    end
    req_cc2mem = 1'b0;
    @(negedge clk);
    collect_read(32'hA5552D0C, 1'b0);
    n_cmp++;
    if (n_acks !== 4 || issue_adr[0] !== 32'hA5552D0C || ack_word[0] !== 2'd3 ||
        ack_word[1] !== 2'd0 || ack_word[2] !== 2'd1 || ack_word[3] !== 2'd2) begin
      n_err++; $display("FAIL hold_next_refill: acks=%0d adr0=%h words=%0d,%0d,%0d,%0d required 4 A5552D0C 3,0,1,2",
                        n_acks, issue_adr[0], ack_word[0], ack_word[1], ack_word[2], ack_word[3]);
    end
    n_cmp++;
    if (done_line !== exp_line) begin
      n_err++; $display("FAIL hold_next_line: got %h required %h", done_line, exp_line);
    end
    req_cc2mem = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    auto_rv = 1'b0; gnt_level = 1'b1;
    req_cc2mem = 1'b1; rdwr_cc2mem = 1'b0; adr_cc2mem = 32'h00002000;
    @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdat = 32'hDEAD0000;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_cmp++;
    if (ack_mem2cc !== 1'b1 || dat_mem2cc !== 32'hDEAD0000) begin
      n_err++; $display("FAIL rstmid_beat0: ack=%0b dat=%h required 1 DEAD0000", ack_mem2cc, dat_mem2cc);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== RD_WAIT) begin
      n_err++; $display("FAIL rstmid_state: got %0d required %0d", state_dbg, RD_WAIT);
    end
    rst = 1'b0; req_cc2mem = 1'b0;
    #1;
    n_cmp++;
    if ({ack_mem2cc, done_mem2cc, dat_mem2cc, word_mem2cc, line_mem2cc,
         mem_req, mem_we, mem_adr, mem_wdat} !== '0 || state_dbg !== IDLE) begin
      n_err++; $display("FAIL rstmid_outputs: ack=%0b dat=%h line=%h req=%0b adr=%h state=%0d required all 0",
                        ack_mem2cc, dat_mem2cc, line_mem2cc, mem_req, mem_adr, state_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdat = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ack_mem2cc !== 1'b0 || mem_req !== 1'b0) begin
        n_err++; $display("FAIL rstmid_stray%0d: ack=%0b req=%0b required 0 0", i, ack_mem2cc, mem_req);
      end
      @(negedge clk);
    end
    auto_rv = 1'b1;
    collect_read(32'h00002008, 1'b0);
    n_cmp++;
    if (n_acks !== 4 || done_cyc !== 12 || ack_word[0] !== 2'd2 || done_line !== exp_line) begin
      n_err++; $display("FAIL rstmid_refill: acks=%0d done_cyc=%0d word0=%0d line=%h required 4 12 2 %h",
                        n_acks, done_cyc, ack_word[0], done_line, exp_line);
    end
    req_cc2mem = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    collect_read(32'h12345674, 1'b1);
    n_cmp++;
    if (n_acks !== 4 || ack_done[3] !== 1'b1 || ack_done[0] !== 1'b0 || done_cyc !== 12) begin
      n_err++; $display("FAIL drop_acks: acks=%0d done3=%0b done0=%0b done_cyc=%0d required 4 1 0 12",
                        n_acks, ack_done[3], ack_done[0], done_cyc);
    end
    n_cmp++;
    if (ack_word[0] !== 2'd1 || ack_word[1] !== 2'd2 || ack_word[2] !== 2'd3 || ack_word[3] !== 2'd0) begin
      n_err++; $display("FAIL drop_order: words=%0d,%0d,%0d,%0d required 1,2,3,0",
                        ack_word[0], ack_word[1], ack_word[2], ack_word[3]);
    end
    n_cmp++;
    if (done_line !== exp_line) begin
      n_err++; $display("FAIL drop_line: got %h required %h", done_line, exp_line);
    end
    req_cc2mem = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read_wrap();
    test_write();
    test_gnt_stall();
    test_hold_after_done();
    test_reset_mid();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
